sec_rloc30bits: RTL and testbench

Sequential remainder-to-location decoder for the 30-bit AN product code, A = 18613. It takes the 15-bit remainder r = (received mod A) of a codeword with at most one error and returns the signed error location l. Location ±i means an error of ±2^(i-1), for i = 1..45. It is the inverse of the l-to-r location LUT in the SEC correction path. It replaces a 90-entry reverse LUT with a modular-doubling search, one candidate magnitude per cycle.

---
 rtl/sec_an_pkg.sv | 12 +
 rtl/sec_moddouble.sv | 13 +
 rtl/sec_rloc30bits.sv | 89 ++++++++
 tb/tb_sec_rloc30bits.sv | 127 ++++++++++++
 4 files changed

// File: rtl/sec_an_pkg.sv
// sec_an_pkg: constants, FSM state type and helpers for the A=18613 AN-code location search
package sec_an_pkg;
  localparam int unsigned A = 18613;
  localparam int W = 15;
  localparam int LW = 7;
  localparam int NLOC = 45;
  typedef enum logic {IDLE, SEARCH} state_t;
  // Negative image of a residue: the remainder left by an error of -2^(i-1) when +2^(i-1) leaves p
  function automatic logic [W-1:0] neg_img(input logic [W-1:0] p);
    return W'(A) - p;
  endfunction
endpackage

// File: rtl/sec_moddouble.sv
// sec_moddouble: combinational modular doubling p -> 2p mod A for a residue p < A
module sec_moddouble #(
  parameter int unsigned A = 18613,
  parameter int W = 15
) (
  input  logic [W-1:0] i_p,
  output logic [W-1:0] o_p2
);
  logic [W:0] w_t;
  assign w_t = {i_p, 1'b0};
  // 2p < 2A, so a single conditional subtract brings it back into range
  assign o_p2 = (w_t >= (W+1)'(A)) ? W'(w_t - (W+1)'(A)) : w_t[W-1:0];
endmodule

// File: rtl/sec_rloc30bits.sv
// sec_rloc30bits: sequential remainder-to-signed-error-location search, one magnitude per cycle
module sec_rloc30bits
  import sec_an_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [W-1:0]         r,
  output logic                 busy,
  output logic                 done,
  output logic signed [LW-1:0] l,
  output logic                 corr,
  output logic                 unc
);
  state_t              r_state;
  logic [W-1:0]        r_rq;
  logic [W-1:0]        r_p;
  logic [5:0]          r_i;
  logic                r_busy;
  logic                r_done;
  logic signed [LW-1:0] r_l;
  logic                r_corr;
  logic                r_unc;
  logic [W-1:0]        w_n;
  logic [W-1:0]        w_p2;
  logic                w_zero;
  logic                w_big;
  logic                w_hit_p;
  logic                w_hit_n;
  logic                w_last;
  logic                w_fin;
  logic signed [LW-1:0] w_iv;
  logic signed [LW-1:0] w_l;
  logic                w_unc;
  sec_moddouble #(.A(A), .W(W)) u_dbl (.i_p(r_p), .o_p2(w_p2));
  assign w_n = neg_img(r_p);
  assign w_iv = LW'(r_i);
  // p is never 0 (A is odd) and n lies in 1..A-1, so zero/out-of-range cases cannot also hit
  always_comb begin
    w_zero  = r_rq == '0;
    w_big   = (r_i == 6'd1) && (r_rq >= W'(A));
    w_hit_p = r_rq == r_p;
    w_hit_n = r_rq == w_n;
    w_last  = r_i == 6'(NLOC);
    w_fin   = w_zero | w_big | w_hit_p | w_hit_n | w_last;
    w_l     = w_hit_p ? w_iv : w_hit_n ? -w_iv : '0;
    w_unc   = w_big | (w_last & ~w_zero & ~w_hit_p & ~w_hit_n);
  end
  // Search FSM: capture on start, step the doubling each cycle, register the result on finish
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_rq    <= '0;
      r_p     <= '0;
      r_i     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_l     <= '0;
      r_corr  <= 1'b0;
      r_unc   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        if (start) begin
          r_rq    <= r;
          r_i     <= 6'd1;
          r_p     <= W'(1);
          r_busy  <= 1'b1;
          r_state <= SEARCH;
        end
      end else if (w_fin) begin
        r_l     <= w_l;
        r_corr  <= w_hit_p | w_hit_n;
        r_unc   <= w_unc;
        r_done  <= 1'b1;
        r_busy  <= 1'b0;
        r_state <= IDLE;
      end else begin
        r_i <= r_i + 6'd1;
        r_p <= w_p2;
      end
    end
  end
  assign busy = r_busy;
  assign done = r_done;
  assign l    = r_l;
  assign corr = r_corr;
  assign unc  = r_unc;
endmodule

// File: tb/tb_sec_rloc30bits.sv
// tb_sec_rloc30bits: scoreboard bench for the remainder-to-location search
module tb_sec_rloc30bits;
  import sec_an_pkg::*;
  typedef struct {int l; int corr; int unc; int k;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [W-1:0] r = '0;
  logic busy, done, corr, unc;
  logic signed [LW-1:0] l;
  exp_t exp_q[$];
  int acc_q[$];
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  sec_rloc30bits dut (
    .clk(clk), .rst(rst), .start(start), .r(r),
    .busy(busy), .done(done), .l(l), .corr(corr), .unc(unc)
  );
  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask
  // Record the cycle index of every accepted start
  always @(posedge clk) begin
    if (!rst && start && !busy) acc_q.push_back(cyc);
    cyc <= cyc + 1;
  end
  // Monitor: every done strobe is checked against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    int a;
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1, expected no result pending");
      end else begin
        e = exp_q.pop_front();
        a = (acc_q.size() != 0) ? acc_q.pop_front() : -1000;
        chk("l", int'(l), e.l);
        chk("corr", int'(corr), e.corr);
        chk("unc", int'(unc), e.unc);
        chk("latency", cyc - a - 1, e.k);
        chk("busy_in_done", int'(busy), 0);
      end
    end
  end
  task automatic wait_empty();
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout: got %0d results pending, expected 0", exp_q.size());
      exp_q.delete();
      acc_q.delete();
    end
  endtask
  task automatic run_vec(input logic [W-1:0] rv, input int el, input int ec, input int eu, input int ek);
    @(negedge clk);
    exp_q.push_back('{el, ec, eu, ek});
    start = 1'b1;
    r = rv;
    @(negedge clk);
    start = 1'b0;
    r = W'($urandom);
    wait_empty();
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_l"}, int'(l), 0);
    chk({tag, "_corr"}, int'(corr), 0);
    chk({tag, "_unc"}, int'(unc), 0);
  endtask
  initial begin
    #12;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    run_vec(15'd1, 1, 1, 0, 1);
    run_vec(15'd18612, -1, 1, 0, 1);
    run_vec(15'd14155, 16, 1, 0, 16);
    run_vec(15'd615, -28, 1, 0, 28);
    run_vec(15'd3623, 45, 1, 0, 45);
    run_vec(15'd14990, -45, 1, 0, 45);
    run_vec(15'd0, 0, 0, 0, 1);
    run_vec(15'd18613, 0, 0, 1, 1);
    run_vec(15'd5, 0, 0, 1, 45);
    @(negedge clk);
    exp_q.push_back('{16, 1, 0, 16});
    exp_q.push_back('{1, 1, 0, 1});
    start = 1'b1;
    r = 15'd14155;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (done) break;
      r = W'($urandom);
    end
    r = 15'd1;
    @(negedge clk);
    start = 1'b0;
    wait_empty();
    @(negedge clk);
    exp_q.push_back('{-28, 1, 0, 28});
    start = 1'b1;
    r = 15'd615;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("busy_mid_search", int'(busy), 1);
    #2 rst = 1'b1;
    #1 chk_zero("async_reset");
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    rst = 1'b0;
    run_vec(15'd2, 2, 1, 0, 2);
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
